// File: rtl/flag_branch_unit_pkg.sv
// Shared definitions for the flag/branch unit: ALU opcode encoding, CCR bit
// positions and the flush FSM state type.
package flag_branch_unit_pkg;

   localparam logic [4:0] OP_NOP  = 5'd0;
   localparam logic [4:0] OP_SETC = 5'd1;
   localparam logic [4:0] OP_CLRC = 5'd2;
   localparam logic [4:0] OP_NOT  = 5'd3;
   localparam logic [4:0] OP_NEG  = 5'd4;
   localparam logic [4:0] OP_INC  = 5'd5;
   localparam logic [4:0] OP_DEC  = 5'd6;
   localparam logic [4:0] OP_MOV  = 5'd7;
   localparam logic [4:0] OP_SWAP = 5'd8;
   localparam logic [4:0] OP_ADD  = 5'd9;
   localparam logic [4:0] OP_SUB  = 5'd10;
   localparam logic [4:0] OP_AND  = 5'd11;
   localparam logic [4:0] OP_OR   = 5'd12;
   localparam logic [4:0] OP_SHL  = 5'd13;
   localparam logic [4:0] OP_SHR  = 5'd14;
   localparam logic [4:0] OP_LDM  = 5'd15;
   localparam logic [4:0] OP_LDD  = 5'd16;
   localparam logic [4:0] OP_STD  = 5'd17;
   localparam logic [4:0] OP_PUSH = 5'd18;
   localparam logic [4:0] OP_POP  = 5'd19;
   localparam logic [4:0] OP_JZ   = 5'd20;
   localparam logic [4:0] OP_JN   = 5'd21;
   localparam logic [4:0] OP_JC   = 5'd22;
   localparam logic [4:0] OP_JMP  = 5'd23;
   localparam logic [4:0] OP_CALL = 5'd24;
   localparam logic [4:0] OP_RET  = 5'd25;
   localparam logic [4:0] OP_RETI = 5'd26;

   localparam int FLG_C = 0;
   localparam int FLG_Z = 1;
   localparam int FLG_N = 2;
   localparam int FLG_V = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational branch condition evaluation: decides whether a control-flow
// opcode is taken and which CCR flag a taken conditional jump consumes.
module branch_cond_eval
   import flag_branch_unit_pkg::*;
#(
   parameter int CTRL_W = 5
) (
   input  logic [CTRL_W-1:0] alu_control,
   input  logic [3:0]        ccr,
   output logic              taken,
   output logic [3:0]        clr_mask
);

   always_comb begin
      taken    = 1'b0;
      clr_mask = 4'b0000;
      case (alu_control)
         CTRL_W'(OP_JZ): begin
            taken = ccr[FLG_Z];
            clr_mask[FLG_Z] = ccr[FLG_Z];
         end
         CTRL_W'(OP_JN): begin
            taken = ccr[FLG_N];
            clr_mask[FLG_N] = ccr[FLG_N];
         end
         CTRL_W'(OP_JC): begin
            taken = ccr[FLG_C];
            clr_mask[FLG_C] = ccr[FLG_C];
         end
         CTRL_W'(OP_JMP), CTRL_W'(OP_CALL), CTRL_W'(OP_RET), CTRL_W'(OP_RETI): begin
            taken = 1'b1;
         end
         default: begin
            taken    = 1'b0;
            clr_mask = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/flag_branch_unit.sv
// Execute-stage flag/branch unit: owns the CCR and its interrupt shadow, resolves
// jumps/calls/returns and drives a registered branch target plus multi-cycle flush.
module flag_branch_unit
   import flag_branch_unit_pkg::*;
#(
   parameter int CTRL_W       = 5,
   parameter int ADDR_W       = 16,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic [CTRL_W-1:0] alu_control,
   input  logic [3:0]        alu_flags,
   input  logic [3:0]        flag_we,
   input  logic [ADDR_W-1:0] target,
   input  logic              int_req,
   output logic [3:0]        ccr,
   output logic              branch_taken,
   output logic [ADDR_W-1:0] branch_target,
   output logic              flush
);

   state_t              r_state;
   state_t              w_stateNext;
   logic [2:0]          r_flushCnt;
   logic [2:0]          w_flushCntNext;
   logic [3:0]          r_ccr;
   logic [3:0]          r_shadow;
   logic [3:0]          w_ccrNext;
   logic                r_branchTaken;
   logic [ADDR_W-1:0]   r_branchTarget;
   logic                w_accept;
   logic                w_take;
   logic                w_condTaken;
   logic [3:0]          w_clrMask;
   logic                w_aluOp;

   branch_cond_eval #(
      .CTRL_W(CTRL_W)
   ) u_cond (
      .alu_control(alu_control),
      .ccr        (r_ccr),
      .taken      (w_condTaken),
      .clr_mask   (w_clrMask)
   );

   // Jumps test the registered CCR, so a flag write only reaches a jump one cycle later.
   always_comb begin
      w_accept  = valid_in && (r_state == ST_IDLE);
      w_take    = w_accept && w_condTaken;
      w_aluOp   = (alu_control >= CTRL_W'(OP_NOT)) && (alu_control <= CTRL_W'(OP_SHR));
      w_ccrNext = r_ccr;
      if (w_accept) begin
         if (alu_control == CTRL_W'(OP_SETC)) begin
            w_ccrNext[FLG_C] = 1'b1;
         end else if (alu_control == CTRL_W'(OP_CLRC)) begin
            w_ccrNext[FLG_C] = 1'b0;
         end else if (w_aluOp) begin
            w_ccrNext = (r_ccr & ~flag_we) | (alu_flags & flag_we);
         end else if (alu_control == CTRL_W'(OP_RETI)) begin
            w_ccrNext = r_shadow;
         end else if (w_condTaken) begin
            w_ccrNext = r_ccr & ~w_clrMask;
         end
      end
   end

   always_comb begin
      w_stateNext    = r_state;
      w_flushCntNext = r_flushCnt;
      case (r_state)
         ST_IDLE: begin
            if (w_take) begin
               w_stateNext    = ST_FLUSH;
               w_flushCntNext = 3'(FLUSH_CYCLES);
            end
         end
         ST_FLUSH: begin
            if (r_flushCnt <= 3'd1) begin
               w_stateNext    = ST_IDLE;
               w_flushCntNext = 3'd0;
            end else begin
               w_flushCntNext = r_flushCnt - 3'd1;
            end
         end
         default: begin
            w_stateNext    = ST_IDLE;
            w_flushCntNext = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_flushCnt     <= 3'd0;
         r_ccr          <= 4'b0000;
         r_shadow       <= 4'b0000;
         r_branchTaken  <= 1'b0;
         r_branchTarget <= '0;
      end else begin
         r_state       <= w_stateNext;
         r_flushCnt    <= w_flushCntNext;
         r_ccr         <= w_ccrNext;
         r_branchTaken <= w_take;
         if (w_take) begin
            r_branchTarget <= target;
         end
         // Shadow captures the post-edge CCR so a same-cycle RETI or flag write is kept.
         if (int_req) begin
            r_shadow <= w_ccrNext;
         end
      end
   end

   assign ccr           = r_ccr;
   assign branch_taken  = r_branchTaken;
   assign branch_target = r_branchTarget;
   assign flush         = (r_state == ST_FLUSH);

endmodule
